// File: rtl/alu_writeback_seq_pkg.sv
// Shared definitions for the ALU writeback sequencer: condition codes,
// flag bit positions and sequencer state encoding.
package alu_writeback_seq_pkg;

  localparam int unsigned COND_W  = 4;
  localparam int unsigned FLAGS_W = 5;
  localparam int unsigned NZCV_W  = 4;

  localparam logic [COND_W-1:0] COND_EQ = 4'h0;
  localparam logic [COND_W-1:0] COND_NE = 4'h1;
  localparam logic [COND_W-1:0] COND_CS = 4'h2;
  localparam logic [COND_W-1:0] COND_CC = 4'h3;
  localparam logic [COND_W-1:0] COND_MI = 4'h4;
  localparam logic [COND_W-1:0] COND_PL = 4'h5;
  localparam logic [COND_W-1:0] COND_VS = 4'h6;
  localparam logic [COND_W-1:0] COND_VC = 4'h7;
  localparam logic [COND_W-1:0] COND_HI = 4'h8;
  localparam logic [COND_W-1:0] COND_LS = 4'h9;
  localparam logic [COND_W-1:0] COND_GE = 4'hA;
  localparam logic [COND_W-1:0] COND_LT = 4'hB;
  localparam logic [COND_W-1:0] COND_GT = 4'hC;
  localparam logic [COND_W-1:0] COND_LE = 4'hD;
  localparam logic [COND_W-1:0] COND_AL = 4'hE;
  localparam logic [COND_W-1:0] COND_NV = 4'hF;

  // Bit positions within {Q,N,Z,C,V}; N..V also index the 4-bit NZCV view
  localparam int unsigned FLAG_Q = 4;
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_W1   = 2'd1,
    ST_W2   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_writeback_seq_cond_eval.sv
// Combinational ARM condition check of a cond field against NZCV flags.
module alu_writeback_seq_cond_eval
  import alu_writeback_seq_pkg::*;
(
  input  logic [COND_W-1:0] cond_i,
  input  logic [NZCV_W-1:0] nzcv_i,
  output logic              pass_o
);

  logic n, z, c, v;

  assign n = nzcv_i[FLAG_N];
  assign z = nzcv_i[FLAG_Z];
  assign c = nzcv_i[FLAG_C];
  assign v = nzcv_i[FLAG_V];

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_writeback_seq.sv
// ALU result consumer: condition check, flag commit and one- or two-cycle
// register-file write sequencing with issue stall for dual-destination ops.
module alu_writeback_seq
  import alu_writeback_seq_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COND_W-1:0]  cond,
  input  logic [FLAGS_W-1:0] alu_flags,
  input  logic [1:0]         flag_w,
  input  logic               reg_w,
  input  logic               mem_w,
  input  logic               pcs,
  input  logic               no_write,
  input  logic               dual,
  input  logic [AW-1:0]      rd1,
  input  logic [AW-1:0]      rd2,
  input  logic [DW-1:0]      result1,
  input  logic [DW-1:0]      result2,
  input  logic               q_clr,
  output logic               rf_we,
  output logic [AW-1:0]      rf_wa,
  output logic [DW-1:0]      rf_wd,
  output logic               mem_we,
  output logic               pc_src,
  output logic               carry_flag,
  output logic [FLAGS_W-1:0] flags
);

  state_e               state_q, state_d;
  logic [FLAGS_W-1:0]   flags_q, flags_d;
  logic                 in_ready_q, in_ready_d;
  logic                 rf_we_q, rf_we_d;
  logic [AW-1:0]        rf_wa_q, rf_wa_d;
  logic [DW-1:0]        rf_wd_q, rf_wd_d;
  logic                 mem_we_q, mem_we_d;
  logic                 pc_src_q, pc_src_d;
  logic                 dual_pass_q, dual_pass_d;
  logic [AW-1:0]        rd2_q, rd2_d;
  logic [DW-1:0]        result2_q, result2_d;
  logic                 accept_c;
  logic                 pass_c;

  alu_writeback_seq_cond_eval u_cond_eval (
    .cond_i (cond),
    .nzcv_i (flags_q[NZCV_W-1:0]),
    .pass_o (pass_c)
  );

  assign accept_c = in_valid && in_ready_q;

  // Outputs are registered, so each write is prepared on the edge that enters its state
  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    in_ready_d  = 1'b1;
    rf_we_d     = 1'b0;
    rf_wa_d     = rf_wa_q;
    rf_wd_d     = rf_wd_q;
    mem_we_d    = 1'b0;
    pc_src_d    = 1'b0;
    dual_pass_d = 1'b0;
    rd2_d       = rd2_q;
    result2_d   = result2_q;

    if ((state_q == ST_W1) && dual_pass_q) begin
      state_d = ST_W2;
      rf_we_d = 1'b1;
      rf_wa_d = rd2_q;
      rf_wd_d = result2_q;
    end else if (accept_c) begin
      state_d     = ST_W1;
      rf_we_d     = reg_w && pass_c && !no_write;
      rf_wa_d     = rd1;
      rf_wd_d     = result1;
      mem_we_d    = mem_w && pass_c;
      pc_src_d    = pcs && pass_c;
      dual_pass_d = dual && pass_c;
      rd2_d       = rd2;
      result2_d   = result2;
      in_ready_d  = !(dual && pass_c);
    end else begin
      state_d = ST_IDLE;
    end

    // Clear before set so a coincident Q set wins over q_clr
    if (q_clr) begin
      flags_d[FLAG_Q] = 1'b0;
    end
    if (accept_c && pass_c) begin
      if (flag_w[1]) begin
        flags_d[FLAG_N] = alu_flags[FLAG_N];
        flags_d[FLAG_Z] = alu_flags[FLAG_Z];
      end
      if (flag_w[0]) begin
        flags_d[FLAG_C] = alu_flags[FLAG_C];
        flags_d[FLAG_V] = alu_flags[FLAG_V];
      end
      if (alu_flags[FLAG_Q]) begin
        flags_d[FLAG_Q] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      rf_we_q     <= 1'b0;
      rf_wa_q     <= '0;
      rf_wd_q     <= '0;
      mem_we_q    <= 1'b0;
      pc_src_q    <= 1'b0;
      dual_pass_q <= 1'b0;
      rd2_q       <= '0;
      result2_q   <= '0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      rf_we_q     <= rf_we_d;
      rf_wa_q     <= rf_wa_d;
      rf_wd_q     <= rf_wd_d;
      mem_we_q    <= mem_we_d;
      pc_src_q    <= pc_src_d;
      dual_pass_q <= dual_pass_d;
      rd2_q       <= rd2_d;
      result2_q   <= result2_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign rf_we      = rf_we_q;
  assign rf_wa      = rf_wa_q;
  assign rf_wd      = rf_wd_q;
  assign mem_we     = mem_we_q;
  assign pc_src     = pc_src_q;
  assign flags      = flags_q;
  assign carry_flag = flags_q[FLAG_C];

endmodule
